// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode constants, ALU op codes and the ID/EX control bundle.
package decode_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   // M ops sit at 8 + funct3 (MUL..REMU); they share codes with OR/AND/PASSB,
   // so execute tells them apart by the funct3 carried in the bundle.
   localparam logic [3:0] ALU_MUL = 4'd8;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       alu_src;
      logic [3:0] alu_op;
      logic [2:0] funct3;
   } decode_ctrl_t;

   function automatic logic [3:0] alu_base(input logic [2:0] f3,
                                           input logic       alt);
      logic [3:0] op;
      case (f3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_cycle_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction, sign-extended from bit 31.
// R-type, FENCE and unknown opcodes produce zero.
module imm_gen
   import decode_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [31:0] imm_o
);

   logic s;
   assign s = instr_i[31];

   always_comb begin
      imm_o = '0;
      case (instr_i[6:0])
         OPC_LOAD, OPC_OPIMM, OPC_JALR:
            imm_o = {{20{s}}, instr_i[31:20]};
         OPC_STORE:
            imm_o = {{20{s}}, instr_i[31:25], instr_i[11:7]};
         OPC_BRANCH:
            imm_o = {{19{s}}, s, instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm_o = {instr_i[31:12], 12'b0};
         OPC_JAL:
            imm_o = {{11{s}}, s, instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
         default:
            imm_o = '0;
      endcase
   end

endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode into a single-entry ID/EX register with handshake.
// Define DECODE_RV32M_EN to decode the M-extension multiply/divide group.
module decode_cycle
   import decode_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [31:0]      instr_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] pc_out,
   output logic [4:0]       rs1_addr,
   output logic [4:0]       rs2_addr,
   output logic [4:0]       rd_addr,
   output logic [31:0]      imm,
   output decode_ctrl_t     ctrl,
   output logic             illegal
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = instr_in[6:0];
   assign f3  = instr_in[14:12];
   assign f7  = instr_in[31:25];

   logic [31:0]  imm_d;
   decode_ctrl_t ctrl_d;
   logic         ill_d;

   imm_gen u_imm_gen (
      .instr_i (instr_in),
      .imm_o   (imm_d)
   );

   always_comb begin
      ctrl_d = '0;
      ill_d  = 1'b0;
      unique case (opc)
         OPC_LUI: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_op    = ALU_PASSB;
         end
         OPC_AUIPC: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_op    = ALU_ADD;
         end
         OPC_JAL: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.jump      = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_op    = ALU_ADD;
         end
         OPC_JALR: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.jump      = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_op    = ALU_ADD;
            ctrl_d.funct3    = f3;
            ill_d            = (f3 != 3'd0);
         end
         OPC_BRANCH: begin
            ctrl_d.branch = 1'b1;
            ctrl_d.alu_op = ALU_SUB;
            ctrl_d.funct3 = f3;
            ill_d         = (f3 == 3'd2) || (f3 == 3'd3);
         end
         OPC_LOAD: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.mem_read  = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_op    = ALU_ADD;
            ctrl_d.funct3    = f3;
            ill_d            = (f3 == 3'd3) || (f3 >= 3'd6);
         end
         OPC_STORE: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_op    = ALU_ADD;
            ctrl_d.funct3    = f3;
            ill_d            = (f3 > 3'd2);
         end
         OPC_OPIMM: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.funct3    = f3;
            ctrl_d.alu_op    = alu_base(f3, (f3 == 3'd5) && f7[5]);
            // only shift-immediates constrain funct7
            if (f3 == 3'd1)
               ill_d = (f7 != 7'h00);
            else if (f3 == 3'd5)
               ill_d = (f7 != 7'h00) && (f7 != 7'h20);
         end
         OPC_OP: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.funct3    = f3;
            if (f7 == 7'h00)
               ctrl_d.alu_op = alu_base(f3, 1'b0);
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
               ctrl_d.alu_op = alu_base(f3, 1'b1);
            else if (f7 == 7'h01)
`ifdef DECODE_RV32M_EN
               ctrl_d.alu_op = ALU_MUL | {1'b0, f3};
`else
               ill_d = 1'b1;
`endif
            else
               ill_d = 1'b1;
         end
         OPC_FENCE: begin
            ctrl_d = '0;
         end
         default: begin
            ill_d = 1'b1;
         end
      endcase
      if (ill_d)
         ctrl_d = '0;
      if (instr_in[11:7] == 5'd0)
         ctrl_d.reg_write = 1'b0;
   end

   logic             valid_q;
   logic [WIDTH-1:0] pc_q;
   logic [4:0]       rs1_q;
   logic [4:0]       rs2_q;
   logic [4:0]       rd_q;
   logic [31:0]      imm_q;
   decode_ctrl_t     ctrl_q;
   logic             ill_q;

   logic load;
   logic xfer;

   assign in_ready = !valid_q || out_ready;
   assign load     = in_valid && in_ready;
   assign xfer     = valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
         ctrl_q  <= '0;
         ill_q   <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         pc_q    <= pc_in;
         rs1_q   <= instr_in[19:15];
         rs2_q   <= instr_in[24:20];
         rd_q    <= instr_in[11:7];
         imm_q   <= imm_d;
         ctrl_q  <= ctrl_d;
         ill_q   <= ill_d;
      end else if (xfer) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid = valid_q;
   assign pc_out    = pc_q;
   assign rs1_addr  = rs1_q;
   assign rs2_addr  = rs2_q;
   assign rd_addr   = rd_q;
   assign imm       = imm_q;
   assign ctrl      = ctrl_q;
   assign illegal   = ill_q;

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed and randomized checks of decode_cycle
// against a behavioural decode model and a single-entry scoreboard.
module tb_decode_cycle;
   import decode_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  pc_in;
   logic [31:0]  instr_in;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  pc_out;
   logic [4:0]   rs1_addr;
   logic [4:0]   rs2_addr;
   logic [4:0]   rd_addr;
   logic [31:0]  imm;
   decode_ctrl_t ctrl;
   logic         illegal;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] imm;
      logic        ill;
      logic        rw, mr, mw, br, jp, src;
      logic [3:0]  op;
      logic [2:0]  f3;
   } exp_t;

   exp_t cur;
   bit   cur_v = 1'b0;
   int   dut_xfer = 0;

   always #5 clk = ~clk;

   decode_cycle #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pc_in     (pc_in),
      .instr_in  (instr_in),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pc_out    (pc_out),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rd_addr   (rd_addr),
      .imm       (imm),
      .ctrl      (ctrl),
      .illegal   (illegal)
   );

   function automatic exp_t ref_decode(input logic [31:0] pc,
                                       input logic [31:0] w);
      exp_t        e;
      logic [31:0] sx;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [7:0]  m;
      logic        legal;
      int          base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      sx = {32{w[31]}};
      f3 = w[14:12];
      f7 = w[31:25];
      e.pc = pc; e.instr = w; e.imm = '0; e.ill = 1'b0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0; e.src = 0;
      e.op = '0; e.f3 = '0;
      legal = 1'b1;
      case (w[6:0])
         7'h37: begin
            e.rw = 1; e.src = 1; e.op = 4'd10;
            e.imm = w & 32'hFFFFF000;
         end
         7'h17: begin
            e.rw = 1; e.src = 1;
            e.imm = w & 32'hFFFFF000;
         end
         7'h6F: begin
            e.rw = 1; e.jp = 1; e.src = 1;
            e.imm = (sx << 20) | (32'(w[19:12]) << 12)
                  | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
         end
         7'h67: begin
            e.rw = 1; e.jp = 1; e.src = 1; e.f3 = f3;
            e.imm = 32'($signed(w) >>> 20);
            legal = (f3 == 0);
         end
         7'h63: begin
            e.br = 1; e.op = 4'd1; e.f3 = f3;
            e.imm = (sx << 12) | (32'(w[7]) << 11)
                  | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            m = 8'hF3; legal = m[f3];
         end
         7'h03: begin
            e.mr = 1; e.rw = 1; e.src = 1; e.f3 = f3;
            e.imm = 32'($signed(w) >>> 20);
            m = 8'h37; legal = m[f3];
         end
         7'h23: begin
            e.mw = 1; e.src = 1; e.f3 = f3;
            e.imm = (sx << 11) | (32'(w[30:25]) << 5) | 32'(w[11:7]);
            m = 8'h07; legal = m[f3];
         end
         7'h13: begin
            e.rw = 1; e.src = 1; e.f3 = f3;
            e.imm = 32'($signed(w) >>> 20);
            e.op = 4'(base[f3]);
            if (f3 == 1) legal = (f7 == 0);
            if (f3 == 5) begin
               if (f7 == 7'h20) e.op = 4'd7;
               else legal = (f7 == 0);
            end
         end
         7'h33: begin
            e.rw = 1; e.f3 = f3;
            if (f7 == 0) e.op = 4'(base[f3]);
            else if (f7 == 7'h20 && f3 == 0) e.op = 4'd1;
            else if (f7 == 7'h20 && f3 == 5) e.op = 4'd7;
`ifdef DECODE_RV32M_EN
            else if (f7 == 7'h01) e.op = 4'(8 + f3);
`endif
            else legal = 1'b0;
         end
         7'h0F: begin
            e.imm = '0;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         e.ill = 1; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0;
      end
      if (w[11:7] == 0) e.rw = 0;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  opcs [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
      logic [6:0]  f7s [3] = '{7'h00, 7'h20, 7'h01};
      w = $urandom;
      if ($urandom_range(0, 7) != 0) begin
         w[6:0] = opcs[$urandom_range(0, 9)];
         if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) &&
             $urandom_range(0, 3) != 0)
            w[31:25] = f7s[$urandom_range(0, 2)];
         if ($urandom_range(0, 3) == 0) w[14:12] = 3'd0;
      end
      return w;
   endfunction

   // one clock: check against the model at negedge, advance it at posedge
   task automatic step(input bit rst, input bit iv, input logic [31:0] pc,
                       input logic [31:0] ins, input bit ordy,
                       input bit fl);
      bit acc;
      bit xf;
      reset = rst; in_valid = iv; pc_in = pc; instr_in = ins;
      out_ready = ordy; flush = fl;
      @(negedge clk);
      checks++;
      if (in_ready !== (!cur_v || ordy)) begin
         errors++;
         $display("FAIL in_ready: got %b want %b", in_ready, !cur_v || ordy);
      end
      checks++;
      if (out_valid !== cur_v) begin
         errors++;
         $display("FAIL out_valid: got %b want %b", out_valid, cur_v);
      end
      if (cur_v) begin
         checks++;
         if (pc_out !== cur.pc) begin
            errors++;
            $display("FAIL pc_out: got %h want %h", pc_out, cur.pc);
         end
         checks++;
         if ({rs1_addr, rs2_addr, rd_addr} !==
             {cur.instr[19:15], cur.instr[24:20], cur.instr[11:7]}) begin
            errors++;
            $display("FAIL addrs %h: got %0d/%0d/%0d", cur.instr,
                     rs1_addr, rs2_addr, rd_addr);
         end
         checks++;
         if (illegal !== cur.ill) begin
            errors++;
            $display("FAIL illegal %h: got %b want %b", cur.instr,
                     illegal, cur.ill);
         end
         checks++;
         if ({ctrl.reg_write, ctrl.mem_read, ctrl.mem_write, ctrl.branch,
              ctrl.jump} !== {cur.rw, cur.mr, cur.mw, cur.br, cur.jp}) begin
            errors++;
            $display("FAIL ctrl_bits %h: got %b want %b", cur.instr,
                     {ctrl.reg_write, ctrl.mem_read, ctrl.mem_write,
                      ctrl.branch, ctrl.jump},
                     {cur.rw, cur.mr, cur.mw, cur.br, cur.jp});
         end
         if (!cur.ill) begin
            checks++;
            if (imm !== cur.imm) begin
               errors++;
               $display("FAIL imm %h: got %h want %h", cur.instr, imm, cur.imm);
            end
            checks++;
            if ({ctrl.alu_src, ctrl.alu_op, ctrl.funct3} !==
                {cur.src, cur.op, cur.f3}) begin
               errors++;
               $display("FAIL alu %h: got %b/%0d/%0d want %b/%0d/%0d",
                        cur.instr, ctrl.alu_src, ctrl.alu_op, ctrl.funct3,
                        cur.src, cur.op, cur.f3);
            end
         end
      end
      if (out_valid === 1'b1 && ordy) dut_xfer++;
      @(posedge clk);
      acc = iv && (!cur_v || ordy);
      xf  = cur_v && ordy;
      if (rst) cur_v = 1'b0;
      else if (fl) cur_v = 1'b0;
      else if (acc) begin
         cur   = ref_decode(pc, ins);
         cur_v = 1'b1;
      end else if (xf) cur_v = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      pc_in = '0; instr_in = '0;
      repeat (2) @(posedge clk);
      #1;
      cur_v = 1'b0;
      checks++;
      if ({out_valid, pc_out, rs1_addr, rs2_addr, rd_addr, imm, ctrl,
           illegal} !== '0) begin
         errors++;
         $display("FAIL reset_state: got v=%b pc=%h imm=%h ctrl=%h ill=%b",
                  out_valid, pc_out, imm, ctrl, illegal);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_addi();
      step(0, 1, 32'h100, 32'h00510093, 1, 0);
      checks++;
      if ({out_valid, rd_addr, rs1_addr, imm, ctrl.alu_src, ctrl.reg_write,
           pc_out} !== {1'b1, 5'd1, 5'd2, 32'd5, 1'b1, 1'b1, 32'h100}) begin
         errors++;
         $display("FAIL addi: got v=%b rd=%0d rs1=%0d imm=%h src=%b rw=%b pc=%h",
                  out_valid, rd_addr, rs1_addr, imm, ctrl.alu_src,
                  ctrl.reg_write, pc_out);
      end
   endtask

   task automatic test_branch();
      step(0, 1, 32'h104, 32'hFE000EE3, 1, 0);
      checks++;
      if ({imm, ctrl.branch, ctrl.reg_write} !==
          {32'hFFFFFFFC, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL beq: got imm=%h br=%b rw=%b", imm, ctrl.branch,
                  ctrl.reg_write);
      end
   endtask

   task automatic test_lui();
      step(0, 1, 32'h108, 32'h123452B7, 1, 0);
      checks++;
      if ({imm, rd_addr} !== {32'h12345000, 5'd5}) begin
         errors++;
         $display("FAIL lui: got imm=%h rd=%0d", imm, rd_addr);
      end
   endtask

   task automatic test_stall();
      logic [31:0] snap_pc;
      logic [31:0] snap_imm;
      logic [12:0] snap_ctrl;
      int          x0;
      step(0, 1, 32'h200, 32'h00A00513, 1, 0);
      snap_pc = pc_out; snap_imm = imm; snap_ctrl = ctrl;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 32'h204 + 32'(4 * i), rand_instr(), 0, 0);
         checks++;
         if ({out_valid, pc_out, imm, ctrl} !==
             {1'b1, snap_pc, snap_imm, snap_ctrl}) begin
            errors++;
            $display("FAIL stall_hold: got pc=%h imm=%h", pc_out, imm);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: got %b want 0", in_ready);
         end
      end
      x0 = dut_xfer;
      step(0, 1, 32'h300, 32'h00C00613, 1, 0);
      checks++;
      if ({pc_out, out_valid, 32'(dut_xfer - x0)} !==
          {32'h300, 1'b1, 32'd1}) begin
         errors++;
         $display("FAIL stall_resume: got pc=%h v=%b xfers=%0d",
                  pc_out, out_valid, dut_xfer - x0);
      end
      step(0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_flush();
      int x0;
      step(0, 1, 32'h400, rand_instr(), 1, 0);
      step(0, 1, 32'h404, rand_instr(), 0, 1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_stalled: got out_valid %b want 0", out_valid);
      end
      step(0, 1, 32'h408, rand_instr(), 1, 0);
      x0 = dut_xfer;
      step(0, 1, 32'h40C, rand_instr(), 1, 1);
      checks++;
      if ({out_valid, 32'(dut_xfer - x0)} !== {1'b0, 32'd1}) begin
         errors++;
         $display("FAIL flush_xfer: got v=%b xfers=%0d want 0/1",
                  out_valid, dut_xfer - x0);
      end
      step(0, 1, 32'h410, rand_instr(), 1, 0);
      step(1, 1, 32'h414, rand_instr(), 0, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_stall: got out_valid %b want 0", out_valid);
      end
   endtask

   task automatic test_mul_illegal();
      step(0, 1, 32'h500, 32'h022081B3, 1, 0);
`ifdef DECODE_RV32M_EN
      checks++;
      if ({illegal, ctrl.alu_op, ctrl.reg_write} !== {1'b0, 4'd8, 1'b1}) begin
         errors++;
         $display("FAIL mul_m: got ill=%b op=%0d rw=%b", illegal,
                  ctrl.alu_op, ctrl.reg_write);
      end
`else
      checks++;
      if ({out_valid, illegal, ctrl.reg_write} !== 3'b110) begin
         errors++;
         $display("FAIL mul_nom: got v=%b ill=%b rw=%b", out_valid,
                  illegal, ctrl.reg_write);
      end
`endif
      step(0, 1, 32'h504, 32'hFFFFFFFF, 1, 0);
      checks++;
      if ({out_valid, illegal, ctrl.reg_write, ctrl.mem_read,
           ctrl.mem_write, ctrl.branch, ctrl.jump} !== 7'b1100000) begin
         errors++;
         $display("FAIL all_ones: got v=%b ill=%b ctrl=%h", out_valid,
                  illegal, ctrl);
      end
   endtask

   task automatic test_back_to_back();
      int x0;
      step(0, 0, 0, 0, 1, 0);
      x0 = dut_xfer;
      for (int i = 0; i < 20; i++)
         step(0, 1, 32'h600 + 32'(4 * i), rand_instr(), 1, 0);
      checks++;
      if (dut_xfer - x0 != 19) begin
         errors++;
         $display("FAIL back_to_back: got %0d transfers want 19",
                  dut_xfer - x0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
              {$urandom, 2'b00} >> 2 << 2, rand_instr(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      step(0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_branch();
      test_lui();
      test_stall();
      test_flush();
      test_mul_illegal();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Decode pipeline stage that consumes the fetch stage's registered `pc_out`/`instruction` pair. It decodes RV32I fields, control signals and the sign-extended immediate. Results are held in an ID/EX pipeline register with a valid/ready handshake, flush and stall support. It sits between the fetch stage and the execute stage of the five-stage core.

## Interface
Parameters:
- `WIDTH`, 32, datapath/PC width (only 32 supported).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `in_valid` in 1: fetch presents a valid `pc_in`/`instr_in`.
- `in_ready` out 1: stage can accept this cycle.
- `pc_in` in WIDTH: PC of the fetched instruction.
- `instr_in` in 32: fetched instruction word.
- `flush` in 1: kill the held and incoming instruction (branch redirect).
- `out_valid` out 1: ID/EX register holds a valid decoded instruction.
- `out_ready` in 1: execute accepts this cycle.
- `pc_out` out WIDTH: registered PC.
- `rs1_addr`, `rs2_addr`, `rd_addr` out 5 each: register indices.
- `imm` out 32: sign-extended immediate.
- `ctrl` out `decode_ctrl_t`: fields `reg_write`, `mem_read`, `mem_write`, `branch`, `jump`, `alu_src`, `alu_op[3:0]`, `funct3[2:0]`.
- `illegal` out 1: decoded word is not a supported opcode/funct.

## Operation
- Combinational decode of `instr_in` feeds a single-entry ID/EX register.
- Handshake:
  - `in_ready = !out_valid || out_ready`.
  - Load occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
- Register update, in priority order:
  1. `reset`: clear everything.
  2. `flush`: `out_valid` ← 0, incoming load discarded.
  3. Load: capture decode results, `out_valid` ← 1.
  4. Transfer without load: `out_valid` ← 0.
  5. Otherwise: hold all outputs.
- Stall: `out_valid && !out_ready` holds every output bit-stable and deasserts `in_ready`.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (treated as NOP).
- Immediate formats:
  - I: `instr[31:20]` sign-extended.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U: `{instr[31:12], 12'b0}`.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - All formats sign-extend from bit 31.
- R-type instructions produce `imm` = 0.
- `rs2_addr` is driven from `instr[24:20]` regardless of format; execute ignores it when unused.
- Illegal instruction:
  - `illegal` = 1; `reg_write`, `mem_read`, `mem_write`, `branch`, `jump` forced to 0.
  - `out_valid` still asserts so the trap propagates.
- Writes to `rd` = x0: `reg_write` forced to 0.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`.
- Throughput: one instruction per cycle while `out_ready` = 1.
- `in_ready` is combinational from `out_valid`/`out_ready`; it has no path from `in_valid`.
- Reset values: `out_valid` = 0, `pc_out` = 0, all addresses 0, `imm` = 0, `ctrl` all 0, `illegal` = 0. `in_ready` = 1 after reset.
- Reset or flush mid-stall: the entry is dropped next cycle; no output is produced for it.
- Flush in the same cycle as `in_valid`: the input is consumed (`in_ready` honoured) and discarded.
- Flush in the same cycle as a transfer: the transfer completes; the register then empties.

## Configuration
- `DECODE_RV32M_EN`
  - Defined: OP with funct7 = 0000001 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU onto `alu_op` codes 8–15, `reg_write` = 1.
  - Undefined: those encodings set `illegal` = 1.

## Structure
- Package `decode_pkg`:
  - `decode_ctrl_t` packed struct.
  - `alu_op_e` enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, plus M ops.
  - Opcode constants `OPC_*`.
  - `NOP_INSTR` = 32'h00000013.
- Sub-module `imm_gen`: combinational instruction → 32-bit immediate. All other logic stays in `decode_cycle`.

## Test plan
- Reset, then `instr_in` = 0x00510093 (addi x1,x2,5), `pc_in` = 0x100, `out_ready` = 1 → next cycle `out_valid` = 1, `rd_addr` = 1, `rs1_addr` = 2, `imm` = 5, `alu_src` = 1, `reg_write` = 1, `pc_out` = 0x100.
- `instr_in` = 0xFE000EE3 (beq x0,x0,-4) → `imm` = 0xFFFFFFFC, `branch` = 1, `reg_write` = 0.
- `instr_in` = 0x123452B7 (lui x5,0x12345) → `imm` = 0x12345000, `rd_addr` = 5.
- Load an instruction, hold `out_ready` = 0 for 3 cycles while new inputs are presented → outputs stable, `in_ready` = 0; then `out_ready` = 1 → next instruction appears with none lost or duplicated.
- Assert `flush` with `out_valid` = 1 and `in_valid` = 1 → next cycle `out_valid` = 0.
- `instr_in` = 0x022081B3 (mul x3,x1,x2):
  - with `DECODE_RV32M_EN`: `illegal` = 0, `alu_op` = MUL.
  - without: `illegal` = 1, `reg_write` = 0.
- `instr_in` = 0xFFFFFFFF → `illegal` = 1 in both configurations.
